// File: rtl/poker_types.sv
// Shared card types for the poker game blocks.
package poker_types;

    localparam int DECK_SIZE = 52;

    typedef struct packed {
        logic [1:0] suit;
        logic [3:0] rank;
    } card_t;

    // Card k of a freshly ordered deck: suits in blocks of thirteen ranks.
    function automatic card_t card_of(input logic [5:0] k);
        card_t c;
        c.suit = 2'(k / 6'd13);
        c.rank = 4'(k % 6'd13);
        return c;
    endfunction

endpackage

// File: rtl/poker_lfsr.sv
// 16-bit Galois LFSR with loadable seed, shared by the game blocks.
module poker_lfsr #(
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter logic [15:0] MASK    = 16'hB400,
    parameter int          VALUE_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [15:0]        seed,
    input  logic               advance,
    output logic [VALUE_W-1:0] value
);

    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= SEED;
        end else if (load) begin
            // An all-zero state would lock up, so zero selects the default seed.
            lfsr <= (seed == 16'h0) ? SEED : seed;
        end else if (advance) begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? MASK : 16'h0);
        end
    end

    assign value = lfsr[VALUE_W-1:0];

endmodule

// File: rtl/card_dealer.sv
// Card dealer: builds an ordered deck, Fisher-Yates shuffles it with an LFSR,
// then deals one card per ready/valid handshake.
module card_dealer
    import poker_types::card_t, poker_types::card_of;
#(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          DECK_SIZE = 52
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        shuffle_start,
    input  logic [15:0] seed_in,
    output logic        busy,
    output card_t       card_out,
    output logic        card_valid,
    input  logic        card_ready,
    output logic [5:0]  cards_left,
    output logic        empty
);

    typedef enum logic [1:0] {IDLE, INIT, SHUFFLE, DEAL} state_t;

    localparam logic [5:0] LAST = 6'(DECK_SIZE - 1);
    localparam logic [5:0] FULL = 6'(DECK_SIZE);

    state_t     state;
    logic [5:0] k;
    logic [5:0] i;
    logic [5:0] ptr;
    logic [5:0] j;
    logic       accept;
    logic       lfsr_load;
    card_t      deck [DECK_SIZE];

    assign lfsr_load = shuffle_start && (state == IDLE || state == DEAL);
    // Out-of-range candidates are rejected so every surviving j is uniform over 0..i.
    assign accept    = (state == SHUFFLE) && (j <= i);

    poker_lfsr #(
        .SEED    (SEED),
        .MASK    (16'hB400),
        .VALUE_W (6)
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .load    (lfsr_load),
        .seed    (seed_in),
        .advance (state == SHUFFLE),
        .value   (j)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            k     <= '0;
            i     <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (shuffle_start) begin
                        state <= INIT;
                        k     <= '0;
                    end
                end
                INIT: begin
                    k <= k + 6'd1;
                    if (k == LAST) begin
                        state <= SHUFFLE;
                        i     <= LAST;
                    end
                end
                SHUFFLE: begin
                    if (accept) begin
                        i <= i - 6'd1;
                        if (i == 6'd1) begin
                            state <= DEAL;
                            ptr   <= '0;
                        end
                    end
                end
                DEAL: begin
                    // A transfer in this same cycle still completes on the receiver side.
                    if (shuffle_start) begin
                        state <= INIT;
                        k     <= '0;
                        ptr   <= '0;
                    end else if (card_valid && card_ready) begin
                        ptr <= ptr + 6'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the deck is a plain register array with no reset; INIT rewrites every
    // entry before it is read, so resetting it would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            deck[k] <= card_of(k);
        end else if (accept) begin
            deck[i] <= deck[j];
            deck[j] <= deck[i];
        end
    end

    assign busy       = (state == INIT) || (state == SHUFFLE);
    assign card_valid = (state == DEAL) && (ptr < FULL);
    assign card_out   = card_valid ? deck[ptr] : '0;
    assign cards_left = (state == DEAL) ? (FULL - ptr) : 6'd0;
    assign empty      = (cards_left == 6'd0);

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer, checked against an independent shuffle model.
module tb_card_dealer;
    import poker_types::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        shuffle_start = 1'b0;
    logic [15:0] seed_in = 16'h0;
    logic        card_ready = 1'b0;
    logic        busy;
    card_t       card_out;
    logic        card_valid;
    logic [5:0]  cards_left;
    logic        empty;

    int checks = 0;
    int errors = 0;

    logic [5:0] exp_seq [52];
    int         exp_steps;
    logic [5:0] got_seq [52];
    logic [5:0] ref_seq [52];
    int         dealt;

    card_dealer dut (
        .clk           (clk),
        .reset         (reset),
        .shuffle_start (shuffle_start),
        .seed_in       (seed_in),
        .busy          (busy),
        .card_out      (card_out),
        .card_valid    (card_valid),
        .card_ready    (card_ready),
        .cards_left    (cards_left),
        .empty         (empty)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0);
    endfunction

    task automatic model_shuffle(input logic [15:0] s);
        logic [15:0] l;
        logic [5:0]  d [52];
        logic [5:0]  j, t;
        int          idx;
        l = (s == 16'h0) ? 16'hACE1 : s;
        for (int n = 0; n < 52; n++) d[n] = {2'(n / 13), 4'(n % 13)};
        idx = 51;
        exp_steps = 0;
        while (idx > 0 && exp_steps < 5000) begin
            j = l[5:0];
            l = lfsr_step(l);
            exp_steps++;
            if (int'(j) <= idx) begin
                t = d[idx]; d[idx] = d[j]; d[j] = t;
                idx--;
            end
        end
        for (int n = 0; n < 52; n++) exp_seq[n] = d[n];
    endtask

    // Counts busy cycles from the current sample; optionally pulses shuffle_start mid-shuffle.
    task automatic wait_shuffle(input bit glitch);
        int n = 0;
        while (busy === 1'b1 && n < 5000) begin
            n++;
            shuffle_start = glitch && (n == 10 || n == 60);
            seed_in = 16'hFFFF;
            tick;
            shuffle_start = 1'b0;
        end
        dealt = 0;
        checks++;
        if (n !== 52 + exp_steps) begin
            errors++;
            $display("FAIL busy_cycles: got %0d expected %0d", n, 52 + exp_steps);
        end
        checks++;
        if (card_valid !== 1'b1 || cards_left !== 6'd52 || empty !== 1'b0) begin
            errors++;
            $display("FAIL deal_entry: valid=%b left=%0d empty=%b expected 1/52/0",
                     card_valid, cards_left, empty);
        end
    endtask

    task automatic start_shuffle(input logic [15:0] s, input bit glitch);
        model_shuffle(s);
        seed_in = s;
        shuffle_start = 1'b1;
        tick;
        shuffle_start = 1'b0;
        wait_shuffle(glitch);
    endtask

    task automatic deal(input int count, input bit random_ready);
        int    cyc = 0;
        bit    stalled = 1'b0;
        card_t held = '0;
        int    target = dealt + count;
        while (dealt < target && cyc < 5000) begin
            card_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            checks++;
            if (cards_left !== 6'(52 - dealt)) begin
                errors++;
                $display("FAIL cards_left: got %0d expected %0d", cards_left, 52 - dealt);
            end
            if (stalled) begin
                checks++;
                if (card_out !== held) begin
                    errors++;
                    $display("FAIL stall_stable: got %h expected %h", card_out, held);
                end
            end
            if (card_valid && card_ready) begin
                got_seq[dealt] = card_out;
                dealt++;
            end
            stalled = card_valid && !card_ready;
            held = card_out;
            tick;
            cyc++;
        end
        card_ready = 1'b0;
        if (cyc >= 5000) begin
            checks++;
            errors++;
            $display("FAIL deal_timeout: got %0d cards expected %0d", dealt, target);
        end
    endtask

    task automatic check_seq(input int hi, input string name);
        logic [63:0] seen = '0;
        int          bad = 0;
        for (int n = 0; n < hi; n++) begin
            if (got_seq[n] !== exp_seq[n]) bad++;
            if (got_seq[n][3:0] > 4'd12 || seen[got_seq[n]]) bad++;
            seen[got_seq[n]] = 1'b1;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d bad cards, first got %h expected %h", name, bad, got_seq[0], exp_seq[0]);
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if (busy !== 1'b0 || card_valid !== 1'b0 || card_out !== '0 ||
            cards_left !== 6'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL %s: busy=%b valid=%b out=%h left=%0d empty=%b expected 0/0/00/0/1",
                     name, busy, card_valid, card_out, cards_left, empty);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick; tick;
        reset = 1'b0;
        repeat (10) tick;
        check_reset_values("reset_idle");
    endtask

    task automatic test_full_deal;
        start_shuffle(16'h1234, 1'b0);
        deal(52, 1'b0);
        check_seq(52, "seed1234_perm");
        for (int n = 0; n < 52; n++) ref_seq[n] = got_seq[n];
        card_ready = 1'b1;
        repeat (3) tick;
        card_ready = 1'b0;
        checks++;
        if (empty !== 1'b1 || cards_left !== 6'd0 || card_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_after_deal: empty=%b left=%0d valid=%b expected 1/0/0",
                     empty, cards_left, card_valid);
        end
        seed_in = 16'h1234;
        shuffle_start = 1'b1;
        tick;
        shuffle_start = 1'b0;
        checks++;
        if (busy !== 1'b1 || card_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_when_empty: busy=%b valid=%b expected 1/0", busy, card_valid);
        end
        wait_shuffle(1'b0);
        deal(52, 1'b0);
        checks++;
        for (int n = 0; n < 52; n++) begin
            if (got_seq[n] !== ref_seq[n]) begin
                errors++;
                $display("FAIL same_seed_repeat: card %0d got %h expected %h", n, got_seq[n], ref_seq[n]);
                break;
            end
        end
    endtask

    task automatic test_zero_seed;
        start_shuffle(16'h0000, 1'b0);
        deal(52, 1'b0);
        model_shuffle(16'hACE1);
        check_seq(52, "zero_seed_is_ace1");
    endtask

    task automatic test_ignore_start;
        start_shuffle(16'h0BAD, 1'b1);
        deal(52, 1'b0);
        check_seq(52, "start_ignored_when_busy");
    endtask

    task automatic test_stall;
        start_shuffle(16'h5555, 1'b0);
        deal(52, 1'b1);
        check_seq(52, "random_ready_perm");
    endtask

    task automatic test_back_to_back;
        card_t sixth;
        start_shuffle(16'hBEEF, 1'b0);
        deal(5, 1'b0);
        sixth = card_out;
        checks++;
        if (card_valid !== 1'b1 || cards_left !== 6'd47) begin
            errors++;
            $display("FAIL sixth_valid: valid=%b left=%0d expected 1/47", card_valid, cards_left);
        end
        got_seq[5] = sixth;
        card_ready = 1'b1;
        seed_in = 16'h00C3;
        shuffle_start = 1'b1;
        tick;
        shuffle_start = 1'b0;
        card_ready = 1'b0;
        check_seq(6, "six_dealt_before_abort");
        checks++;
        if (busy !== 1'b1 || card_valid !== 1'b0 || cards_left !== 6'd0) begin
            errors++;
            $display("FAIL abort_next_cycle: busy=%b valid=%b left=%0d expected 1/0/0",
                     busy, card_valid, cards_left);
        end
        model_shuffle(16'h00C3);
        wait_shuffle(1'b0);
        deal(52, 1'b0);
        check_seq(52, "perm_after_abort");
    endtask

    task automatic test_reset_mid;
        model_shuffle(16'h7777);
        seed_in = 16'h7777;
        shuffle_start = 1'b1;
        tick;
        shuffle_start = 1'b0;
        repeat (60) tick;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL in_shuffle: busy=%b expected 1", busy);
        end
        reset = 1'b1;
        shuffle_start = 1'b1;
        tick;
        reset = 1'b0;
        shuffle_start = 1'b0;
        check_reset_values("reset_in_shuffle");
        start_shuffle(16'h7777, 1'b0);
        deal(22, 1'b0);
        checks++;
        if (cards_left !== 6'd30) begin
            errors++;
            $display("FAIL left_before_reset: got %0d expected 30", cards_left);
        end
        reset = 1'b1;
        card_ready = 1'b1;
        tick;
        reset = 1'b0;
        card_ready = 1'b0;
        check_reset_values("reset_in_deal");
        // After reset the LFSR holds SEED again, so a zero seed reproduces the 16'hACE1 deal.
        start_shuffle(16'h0000, 1'b0);
        deal(52, 1'b0);
        model_shuffle(16'hACE1);
        check_seq(52, "deal_after_reset");
    endtask

    initial begin
        test_reset;
        test_full_deal;
        test_zero_seed;
        test_ignore_start;
        test_stall;
        test_back_to_back;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
